// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encodings and default drain depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Cycles from HALT leaving ID until the oldest in-flight instruction retires from WB.
  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use detect: a load in EX writes a register that the instruction in ID reads.
// Latency: purely combinational, same cycle.
// Backpressure: none; the sequencer acts on lu.
module load_use_detect #(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_v,
  input  logic             id_rt_v,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  // Only sources the ID instruction actually reads can create a hazard.
  always_comb begin
    lu = ex_memrd & (((ex_rd == id_rs) & id_rs_v) | ((ex_rd == id_rt) & id_rt_v));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives every pipe-register enable and flush strobe for the 5-stage core.
// Latency: outputs combinational from inputs and registered state; FSM state updates next clock.
// Backpressure: dmem_stall freezes all stages; imem_stall/load-use/HALT gate the front end only.
// Optional perf counters: define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 3,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_v,
  input  logic             id_rt_v,
  input  logic             id_halt,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
`ifdef PIPE_HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] mstall_cnt,
`endif
  output logic             halted
);

  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  state_t          state_q, state_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            lu;
  logic            take_lu, take_redir, take_mstall;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_rs_v  (id_rs_v),
    .id_rt_v  (id_rt_v),
    .ex_memrd (ex_memrd),
    .ex_rd    (ex_rd),
    .lu       (lu)
  );

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state and enable/flush decode; reset forces all stages off and flushing.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    take_lu     = 1'b0;
    take_redir  = 1'b0;
    take_mstall = 1'b0;
    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dmem_stall) begin
            // Whole pipe frozen; a pending redirect stays in EX and re-fires later.
            take_mstall = 1'b1;
          end else if (ex_redirect) begin
            take_redir = 1'b1;
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            // Hold PC and IF/ID, insert one bubble behind the load.
            take_lu    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
          end else if (imem_stall || id_halt) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush = 1'b1;
            if (!imem_stall) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = DC_W'(DRAIN_CYCLES - 1);
            end
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          end
        end
        ST_DRAIN: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          take_mstall = dmem_stall;
          if (!dmem_stall) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            if (drain_cnt_q == '0) begin
              state_d = ST_HALTED;
            end else begin
              drain_cnt_d = drain_cnt_q - 1'b1;
            end
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign halted = (state_q == ST_HALTED);

`ifdef PIPE_HAZARD_PERF_CNT_EN
  // Saturating event counters; the take_* strobes are already zero in HALTED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt     <= '0;
      redir_cnt  <= '0;
      mstall_cnt <= '0;
    end else begin
      if (take_lu && (lu_cnt != '1))         lu_cnt     <= lu_cnt + 1'b1;
      if (take_redir && (redir_cnt != '1))   redir_cnt  <= redir_cnt + 1'b1;
      if (take_mstall && (mstall_cnt != '1)) mstall_cnt <= mstall_cnt + 1'b1;
    end
  end
`else
  // Strobes only feed the optional counters.
  logic unused_take;
  assign unused_take = take_lu ^ take_redir ^ take_mstall;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, redirect, memory stalls, HALT drain, async reset.
// Latency: inputs applied 2ns after posedge, outputs sampled 5ns after posedge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_rs_v, id_rt_v, id_halt, ex_memrd, ex_redirect, imem_stall, dmem_stall;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [15:0] lu_cnt, redir_cnt, mstall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // {pc,ifid,idex,exmem,memwb, ifid_flush,idex_flush, halted}
  localparam logic [7:0] V_NORM  = 8'b11111_00_0;
  localparam logic [7:0] V_LU    = 8'b00111_01_0;
  localparam logic [7:0] V_REDIR = 8'b11111_11_0;
  localparam logic [7:0] V_DSTL  = 8'b00000_00_0;
  localparam logic [7:0] V_FRONT = 8'b01111_10_0;
  localparam logic [7:0] V_DRAIN = 8'b01111_11_0;
  localparam logic [7:0] V_DRSTL = 8'b00000_11_0;
  localparam logic [7:0] V_HALT  = 8'b00000_00_1;
  localparam logic [7:0] V_RST   = 8'b00000_11_0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_v     (id_rs_v),
    .id_rt_v     (id_rt_v),
    .id_halt     (id_halt),
    .ex_memrd    (ex_memrd),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .imem_stall  (imem_stall),
    .dmem_stall  (dmem_stall),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
`ifdef PIPE_HAZARD_PERF_CNT_EN
    .lu_cnt      (lu_cnt),
    .redir_cnt   (redir_cnt),
    .mstall_cnt  (mstall_cnt),
`endif
    .halted      (halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] out_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
  endfunction

  task automatic idle_inputs();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_v = 1'b0; id_rt_v = 1'b0; id_halt = 1'b0;
    ex_memrd = 1'b0; ex_rd = 3'd0; ex_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  // Check the current cycle's outputs mid-cycle, then move to 2ns past the next posedge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    #3;
    check_val(tag, {24'd0, out_vec()}, {24'd0, exp});
    @(posedge clk); #2;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #4;
    check_val("reset_outputs", {24'd0, out_vec()}, {24'd0, V_RST});
    tick(); tick();
    rst_n = 1'b1;
    cyc("run_after_reset", V_NORM);

    // Load-use on rs, then load has moved on.
    ex_memrd = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_v = 1'b1;
    cyc("lu_rs", V_LU);
    ex_memrd = 1'b0;
    cyc("lu_released", V_NORM);
    ex_memrd = 1'b1; id_rs_v = 1'b0;
    cyc("lu_rs_not_read", V_NORM);
    id_rt = 3'd3; id_rt_v = 1'b1; id_rs = 3'd5;
    cyc("lu_rt", V_LU);
    ex_rd = 3'd4;
    cyc("lu_reg_differs", V_NORM);

    // Redirect beats load-use.
    ex_rd = 3'd3; ex_redirect = 1'b1;
    cyc("redir_over_lu", V_REDIR);
    idle_inputs();

    // imem stall alone, then load-use beats it.
    imem_stall = 1'b1;
    cyc("imem_stall", V_FRONT);
    ex_memrd = 1'b1; ex_rd = 3'd2; id_rs = 3'd2; id_rs_v = 1'b1;
    cyc("lu_over_imem", V_LU);
    idle_inputs();

    // dmem stall with a pending redirect: 4 frozen cycles, then the redirect fires.
    ex_redirect = 1'b1; dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("dmem_hold%0d", i), V_DSTL);
    dmem_stall = 1'b0;
    cyc("redir_after_dmem", V_REDIR);
    idle_inputs();

    // HALT with clean drain; redirect/halt ignored once draining.
    id_halt = 1'b1;
    cyc("halt_in_id", V_FRONT);
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("drain%0d", i), V_DRAIN);
    cyc("halted0", V_HALT);
    idle_inputs();
    cyc("halted_sticky", V_HALT);
    do_reset();
    cyc("run_after_halt_reset", V_NORM);

    // HALT with a 2-cycle dmem stall inside DRAIN.
    id_halt = 1'b1;
    cyc("halt2_in_id", V_FRONT);
    id_halt = 1'b0;
    cyc("drain2_a", V_DRAIN);
    dmem_stall = 1'b1;
    cyc("drain2_stall0", V_DRSTL);
    cyc("drain2_stall1", V_DRSTL);
    dmem_stall = 1'b0;
    cyc("drain2_b", V_DRAIN);
    cyc("drain2_c", V_DRAIN);
    cyc("halted2", V_HALT);
    do_reset();

    // Async reset in the middle of a DRAIN cycle.
    id_halt = 1'b1;
    cyc("halt3_in_id", V_FRONT);
    id_halt = 1'b0;
    cyc("drain3_a", V_DRAIN);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_midcycle", {24'd0, out_vec()}, {24'd0, V_RST});
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc("run_after_async", V_NORM);
    cyc("still_run", V_NORM);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ex_memrd = 1'b1; ex_rd = 3'd1; id_rs = 3'd1; id_rs_v = 1'b1;
      cyc($sformatf("cnt_lu%0d", i), V_LU);
      idle_inputs();
      cyc($sformatf("cnt_gap%0d", i), V_NORM);
    end
    ex_redirect = 1'b1;
    cyc("cnt_redir", V_REDIR);
    idle_inputs();
    check_val("lu_cnt", {16'd0, lu_cnt}, 32'd5);
    check_val("redir_cnt", {16'd0, redir_cnt}, 32'd1);
    check_val("mstall_cnt_zero", {16'd0, mstall_cnt}, 32'd0);
    dmem_stall = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    dmem_stall = 1'b0;
    tick();
    check_val("mstall_cnt_sat", {16'd0, mstall_cnt}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
